// File: rtl/sys_cmd_initiator.sv
// Host-side command initiator: serializes one command into header/payload byte
// frames for the UART TX path, then waits, with a timeout, for one response byte from RX.
module sys_cmd_initiator #(
  parameter int DW             = 8,
  parameter int FUN_W          = 4,
  parameter int REGFILE_ADDR_W = 4,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_type,
  input  logic [REGFILE_ADDR_W-1:0] cmd_addr,
  input  logic [DW-1:0]             cmd_data,
  input  logic [DW-1:0]             cmd_op_a,
  input  logic [DW-1:0]             cmd_op_b,
  input  logic [FUN_W-1:0]          cmd_fun,
  output logic [DW-1:0]             tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [DW-1:0]             rx_data,
  input  logic                      rx_data_valid,
  output logic [DW-1:0]             rsp_data,
  output logic                      rsp_valid,
  output logic                      rsp_timeout,
  output logic                      cmd_done,
  output logic                      busy
);

  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] T_RF_WR   = 2'd0;
  localparam logic [1:0] T_RF_RD   = 2'd1;
  localparam logic [1:0] T_ALU_OP  = 2'd2;
  localparam logic [1:0] T_ALU_NOP = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

  state_t                    state_reg, state_next;
  logic [1:0]                type_reg, type_next;
  logic [REGFILE_ADDR_W-1:0] addr_reg, addr_next;
  logic [DW-1:0]             data_reg, data_next;
  logic [DW-1:0]             op_a_reg, op_a_next;
  logic [DW-1:0]             op_b_reg, op_b_next;
  logic [FUN_W-1:0]          fun_reg, fun_next;
  logic [2:0]                len_reg, len_next;
  logic [1:0]                idx_reg, idx_next;
  logic [TIMER_W-1:0]        timer_reg, timer_next;
  logic [DW-1:0]             tx_data_reg, tx_data_next;
  logic                      tx_valid_reg, tx_valid_next;
  logic [DW-1:0]             rsp_data_reg, rsp_data_next;
  logic                      rsp_valid_reg, rsp_valid_next;
  logic                      rsp_timeout_reg, rsp_timeout_next;
  logic                      cmd_done_reg, cmd_done_next;

  logic [1:0]    send_idx;
  logic [DW-1:0] body_byte;
  logic [DW-1:0] header_byte;

  assign cmd_ready   = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign cmd_done    = cmd_done_reg;

  // Header comes from the live command so it can be presented the cycle after acceptance.
  always_comb begin
    case (cmd_type)
      T_RF_WR:  header_byte = DW'(8'hAA);
      T_RF_RD:  header_byte = DW'(8'hBB);
      T_ALU_OP: header_byte = DW'(8'hCC);
      default:  header_byte = DW'(8'hDD);
    endcase
  end

  assign send_idx = idx_reg + 2'd1;

  always_comb begin
    body_byte = '0;
    case (type_reg)
      T_RF_WR:  body_byte = (send_idx == 2'd1) ? DW'(addr_reg) : data_reg;
      T_RF_RD:  body_byte = DW'(addr_reg);
      T_ALU_OP: begin
        case (send_idx)
          2'd1:    body_byte = op_a_reg;
          2'd2:    body_byte = op_b_reg;
          default: body_byte = DW'(fun_reg);
        endcase
      end
      default:  body_byte = DW'(fun_reg);
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    type_next        = type_reg;
    addr_next        = addr_reg;
    data_next        = data_reg;
    op_a_next        = op_a_reg;
    op_b_next        = op_b_reg;
    fun_next         = fun_reg;
    len_next         = len_reg;
    idx_next         = idx_reg;
    timer_next       = timer_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = tx_valid_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_valid_next   = 1'b0;
    rsp_timeout_next = 1'b0;
    cmd_done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          type_next     = cmd_type;
          addr_next     = cmd_addr;
          data_next     = cmd_data;
          op_a_next     = cmd_op_a;
          op_b_next     = cmd_op_b;
          fun_next      = cmd_fun;
          case (cmd_type)
            T_RF_WR:  len_next = 3'd3;
            T_ALU_OP: len_next = 3'd4;
            default:  len_next = 3'd2;
          endcase
          idx_next      = 2'd0;
          tx_valid_next = 1'b1;
          tx_data_next  = header_byte;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (tx_valid_reg && tx_ready) begin
          if ({1'b0, idx_reg} == len_reg - 3'd1) begin
            tx_valid_next = 1'b0;
            if (type_reg == T_RF_WR) begin
              cmd_done_next = 1'b1;
              state_next    = IDLE;
            end else begin
              timer_next = '0;
              state_next = WAIT_RSP;
            end
          end else begin
            idx_next     = send_idx;
            tx_data_next = body_byte;
          end
        end
      end
      WAIT_RSP: begin
        // A response arriving on the timeout cycle takes priority over the timeout.
        if (rx_data_valid) begin
          rsp_data_next  = rx_data;
          rsp_valid_next = 1'b1;
          cmd_done_next  = 1'b1;
          state_next     = IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          rsp_timeout_next = 1'b1;
          cmd_done_next    = 1'b1;
          state_next       = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg       <= IDLE;
      type_reg        <= '0;
      addr_reg        <= '0;
      data_reg        <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      fun_reg         <= '0;
      len_reg         <= '0;
      idx_reg         <= '0;
      timer_reg       <= '0;
      tx_data_reg     <= '0;
      tx_valid_reg    <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      cmd_done_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      type_reg        <= type_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
      op_a_reg        <= op_a_next;
      op_b_reg        <= op_b_next;
      fun_reg         <= fun_next;
      len_reg         <= len_next;
      idx_reg         <= idx_next;
      timer_reg       <= timer_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_timeout_reg <= rsp_timeout_next;
      cmd_done_reg    <= cmd_done_next;
    end
  end

endmodule

// File: tb/tb_sys_cmd_initiator.sv
// Directed bench for sys_cmd_initiator: frame bytes, handshake stalls, response,
// timeout, response/timeout collision and mid-frame reset.
module tb_sys_cmd_initiator;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'd0;
  logic [3:0] cmd_addr = 4'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [7:0] cmd_op_a = 8'd0;
  logic [7:0] cmd_op_b = 8'd0;
  logic [3:0] cmd_fun = 4'd0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_valid = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_timeout;
  logic       cmd_done;
  logic       busy;

  int tests = 0;
  int failed = 0;

  sys_cmd_initiator #(
    .DW(8), .FUN_W(4), .REGFILE_ADDR_W(4), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_op_a(cmd_op_a),
    .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout),
    .cmd_done(cmd_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] f);
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_op_a  = opa;
    cmd_op_b  = opb;
    cmd_fun   = f;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    // Scramble the command inputs: the latched copy must be the one sent.
    cmd_addr  = 4'hF;
    cmd_data  = 8'hFF;
    cmd_op_a  = 8'hFF;
    cmd_op_b  = 8'hFF;
    cmd_fun   = 4'hF;
    $display("[TB] cmd type=%0d addr=%0h data=%0h a=%0h b=%0h fun=%0h accepted", t, a, d, opa, opb, f);
  endtask

  initial begin
    logic [7:0] alu_bytes [4];
    alu_bytes[0] = 8'hCC; alu_bytes[1] = 8'h0A; alu_bytes[2] = 8'h03; alu_bytes[3] = 8'h01;

    // Reset state
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_cmd_done", 32'(cmd_done), 32'd0);
    step();
    RST = 1'b1;
    step();

    // RF_WR, tx_ready tied high: AA,05,3C back to back
    tx_ready = 1'b1;
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    check("wr_b0", 32'(tx_data), 32'hAA);
    check("wr_b0_valid", 32'(tx_valid), 32'd1);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    check("wr_b1", 32'(tx_data), 32'h05);
    step();
    check("wr_b2", 32'(tx_data), 32'h3C);
    check("wr_b2_valid", 32'(tx_valid), 32'd1);
    step();
    check("wr_done", 32'(cmd_done), 32'd1);
    check("wr_tx_valid_off", 32'(tx_valid), 32'd0);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    check("wr_ready_again", 32'(cmd_ready), 32'd1);
    step();
    check("wr_done_pulse", 32'(cmd_done), 32'd0);
    $display("[TB] RF_WR frame complete");

    // RF_RD with response 77 strobed 10 cycles after the last byte
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    check("rd_b0", 32'(tx_data), 32'hBB);
    step();
    check("rd_b1", 32'(tx_data), 32'h02);
    step();
    check("rd_wait_tx_valid", 32'(tx_valid), 32'd0);
    check("rd_wait_busy", 32'(busy), 32'd1);
    rx_data = 8'h99;
    rx_data_valid = 1'b0;
    repeat (9) step();
    check("rd_no_early_done", 32'(cmd_done), 32'd0);
    rx_data = 8'h77;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_cmd_done", 32'(cmd_done), 32'd1);
    check("rd_rsp_data", 32'(rsp_data), 32'h77);
    check("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rd_busy_low", 32'(busy), 32'd0);
    step();
    check("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
    $display("[TB] RF_RD response %0h", rsp_data);

    // ALU_OP with tx_ready toggling: each byte must hold while stalled
    tx_ready = 1'b0;
    issue(2'd2, 4'h0, 8'h00, 8'h0A, 8'h03, 4'h1);
    for (int i = 0; i < 4; i++) begin
      check("alu_byte", 32'(tx_data), 32'(alu_bytes[i]));
      check("alu_valid", 32'(tx_valid), 32'd1);
      tx_ready = 1'b0;
      step();
      check("alu_hold", 32'(tx_data), 32'(alu_bytes[i]));
      tx_ready = 1'b1;
      step();
    end
    check("alu_wait_tx_valid", 32'(tx_valid), 32'd0);
    check("alu_wait_busy", 32'(busy), 32'd1);
    repeat (3) step();
    rx_data = 8'h07;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    check("alu_rsp_valid", 32'(rsp_valid), 32'd1);
    check("alu_rsp_data", 32'(rsp_data), 32'h07);
    check("alu_cmd_done", 32'(cmd_done), 32'd1);
    step();
    $display("[TB] ALU_OP response %0h", rsp_data);

    // ALU_NOP without response: timeout 16 cycles after entering WAIT_RSP
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
    check("nop_b0", 32'(tx_data), 32'hDD);
    step();
    check("nop_b1", 32'(tx_data), 32'h02);
    step();
    check("nop_wait_busy", 32'(busy), 32'd1);
    repeat (15) step();
    check("nop_no_early_timeout", 32'(rsp_timeout), 32'd0);
    check("nop_still_busy", 32'(busy), 32'd1);
    step();
    check("nop_timeout", 32'(rsp_timeout), 32'd1);
    check("nop_cmd_done", 32'(cmd_done), 32'd1);
    check("nop_no_rsp_valid", 32'(rsp_valid), 32'd0);
    check("nop_rsp_data_kept", 32'(rsp_data), 32'h07);
    check("nop_idle", 32'(busy), 32'd0);
    step();
    check("nop_timeout_pulse", 32'(rsp_timeout), 32'd0);
    $display("[TB] ALU_NOP timed out");

    // Response arriving exactly on the timeout cycle wins
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3);
    check("col_b0", 32'(tx_data), 32'hDD);
    step();
    check("col_b1", 32'(tx_data), 32'h03);
    step();
    repeat (15) step();
    rx_data = 8'h55;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    check("col_rsp_valid", 32'(rsp_valid), 32'd1);
    check("col_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("col_rsp_data", 32'(rsp_data), 32'h55);
    check("col_cmd_done", 32'(cmd_done), 32'd1);
    step();
    $display("[TB] collision response %0h", rsp_data);

    // Reset during RF_WR after the second byte
    issue(2'd0, 4'h9, 8'h11, 8'h00, 8'h00, 4'h0);
    check("rst_wr_b0", 32'(tx_data), 32'hAA);
    step();
    check("rst_wr_b1", 32'(tx_data), 32'h09);
    step();
    check("rst_wr_b2", 32'(tx_data), 32'h11);
    RST = 1'b0;
    #1;
    check("rst_async_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_rsp_data", 32'(rsp_data), 32'h00);
    #1;
    RST = 1'b1;
    step();
    check("rst_after_ready", 32'(cmd_ready), 32'd1);
    check("rst_after_tx_valid", 32'(tx_valid), 32'd0);
    rx_data = 8'h99;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    check("stray_rx_no_valid", 32'(rsp_valid), 32'd0);
    check("stray_rx_no_done", 32'(cmd_done), 32'd0);
    check("stray_rx_no_capture", 32'(rsp_data), 32'h00);
    issue(2'd1, 4'h6, 8'h00, 8'h00, 8'h00, 4'h0);
    check("post_rst_b0", 32'(tx_data), 32'hBB);
    step();
    check("post_rst_b1", 32'(tx_data), 32'h06);
    step();
    rx_data = 8'h12;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
    check("post_rst_rsp", 32'(rsp_data), 32'h12);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    step();
    $display("[TB] post-reset RF_RD response %0h", rsp_data);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
